// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and load/store,
// sequencing 1/2/4-byte accesses and assembling read data little-endian.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_abort_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      2'd0:    len_to_bytes = 3'd1;
      2'd1:    len_to_bytes = 3'd2;
      default: len_to_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [2:0] idx);
    case (idx)
      3'd0:    pick_byte = word[7:0];
      3'd1:    pick_byte = word[15:8];
      3'd2:    pick_byte = word[23:16];
      3'd3:    pick_byte = word[31:24];
      default: pick_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [2:0] idx,
                                           input logic [7:0] b);
    put_byte = word;
    case (idx)
      3'd0:    put_byte[7:0]   = b;
      3'd1:    put_byte[15:8]  = b;
      3'd2:    put_byte[23:16] = b;
      3'd3:    put_byte[31:24] = b;
      default: put_byte        = word;
    endcase
  endfunction

  state_t            state_r, state_s;
  logic [2:0]        cnt_r, cnt_s, k_s;
  logic [2:0]        len_r, len_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [31:0]       asm_r, asm_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              ram_we_s;
  logic [7:0]        ram_dout_s;
  logic              if_done_s, mem_done_s;
  logic [31:0]       if_data_s, mem_rdata_s;
  logic              grant_ok_s;

  // Next-state, RAM port and completion logic; k_s is the index of the edge being computed
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    len_s       = len_r;
    base_s      = base_r;
    wdata_s     = wdata_r;
    asm_s       = asm_r;
    ram_addr_s  = ram_addr_o;
    ram_we_s    = 1'b0;
    ram_dout_s  = 8'h00;
    if_done_s   = 1'b0;
    mem_done_s  = 1'b0;
    if_data_s   = if_data_o;
    mem_rdata_s = mem_rdata_o;
    k_s         = cnt_r + 3'd1;
    // the done cycle is kept dead so the finished requester can drop its req
    grant_ok_s  = !if_done_o && !mem_done_o;

    case (state_r)
      IDLE: begin
        if (grant_ok_s && mem_req_i) begin
          base_s     = mem_addr_i;
          ram_addr_s = mem_addr_i;
          cnt_s      = 3'd0;
          len_s      = len_to_bytes(mem_len_i);
          wdata_s    = mem_wdata_i;
          asm_s      = 32'h0000_0000;
          if (mem_we_i) begin
            state_s    = MEM_WR;
            ram_we_s   = 1'b1;
            ram_dout_s = mem_wdata_i[7:0];
          end else begin
            state_s    = MEM_RD;
          end
        end else if (grant_ok_s && if_req_i && !if_abort_i) begin
          state_s    = IF_RD;
          base_s     = if_addr_i;
          ram_addr_s = if_addr_i;
          cnt_s      = 3'd0;
          len_s      = 3'd4;
          asm_s      = 32'h0000_0000;
        end else begin
          state_s    = IDLE;
        end
      end

      IF_RD, MEM_RD: begin
        if ((state_r == IF_RD) && if_abort_i) begin
          state_s    = IDLE;
          cnt_s      = 3'd0;
          ram_addr_s = {ADDR_W{1'b0}};
        end else begin
          cnt_s = k_s;
          if (k_s < len_r) begin
            ram_addr_s = base_r + ADDR_W'(k_s);
          end else begin
            ram_addr_s = ram_addr_o;
          end
          // RAM read latency puts byte k on ram_din_i two edges after its address is set
          if (k_s >= 3'd2) begin
            asm_s = put_byte(asm_r, k_s - 3'd2, ram_din_i);
          end else begin
            asm_s = asm_r;
          end
          if (k_s == len_r + 3'd1) begin
            state_s    = IDLE;
            cnt_s      = 3'd0;
            ram_addr_s = {ADDR_W{1'b0}};
            if (state_r == IF_RD) begin
              if_done_s = 1'b1;
              if_data_s = asm_s;
            end else begin
              mem_done_s  = 1'b1;
              mem_rdata_s = asm_s;
            end
          end else begin
            state_s = state_r;
          end
        end
      end

      MEM_WR: begin
        cnt_s = k_s;
        if (k_s < len_r) begin
          ram_we_s   = 1'b1;
          ram_addr_s = base_r + ADDR_W'(k_s);
          ram_dout_s = pick_byte(wdata_r, k_s);
        end else begin
          state_s     = IDLE;
          cnt_s       = 3'd0;
          ram_addr_s  = {ADDR_W{1'b0}};
          mem_done_s  = 1'b1;
          mem_rdata_s = 32'h0000_0000;
        end
      end

      default: begin
        state_s    = IDLE;
        cnt_s      = 3'd0;
        ram_addr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction at its edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      len_r       <= 3'd0;
      base_r      <= {ADDR_W{1'b0}};
      wdata_r     <= 32'h0000_0000;
      asm_r       <= 32'h0000_0000;
      ram_addr_o  <= {ADDR_W{1'b0}};
      ram_we_o    <= 1'b0;
      ram_dout_o  <= 8'h00;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_data_o   <= 32'h0000_0000;
      mem_rdata_o <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      len_r       <= len_s;
      base_r      <= base_s;
      wdata_r     <= wdata_s;
      asm_r       <= asm_s;
      ram_addr_o  <= ram_addr_s;
      ram_we_o    <= ram_we_s;
      ram_dout_o  <= ram_dout_s;
      if_done_o   <= if_done_s;
      mem_done_o  <= mem_done_s;
      if_data_o   <= if_data_s;
      mem_rdata_o <= mem_rdata_s;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven loads/stores plus hand-written fetch,
// arbitration, abort, reset and address-wrap sequences against byte-wide RAM models.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, if_done, m_req, m_we, m_done, ram_we;
  logic [31:0] if_addr, if_data, m_addr, m_wdata, m_rdata, ram_addr;
  logic [1:0]  m_len;
  logic [7:0]  ram_dout, ram_din;

  logic        m8_req, m8_we, m8_done, r8_we, i8_done, i8_req, i8_abort;
  logic [1:0]  m8_len;
  logic [7:0]  m8_addr, r8_addr, r8_dout, r8_din, i8_addr;
  logic [31:0] m8_wdata, m8_rdata, i8_data;

  logic [7:0]  ram  [0:1023];
  logic [7:0]  ram8 [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_abort_i(if_abort),
    .if_data_o(if_data), .if_done_o(if_done),
    .mem_req_i(m_req), .mem_we_i(m_we), .mem_len_i(m_len), .mem_addr_i(m_addr),
    .mem_wdata_i(m_wdata), .mem_rdata_o(m_rdata), .mem_done_o(m_done),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_dout_o(ram_dout), .ram_din_i(ram_din)
  );

  mem_arbiter #(.ADDR_W(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .if_req_i(i8_req), .if_addr_i(i8_addr), .if_abort_i(i8_abort),
    .if_data_o(i8_data), .if_done_o(i8_done),
    .mem_req_i(m8_req), .mem_we_i(m8_we), .mem_len_i(m8_len), .mem_addr_i(m8_addr),
    .mem_wdata_i(m8_wdata), .mem_rdata_o(m8_rdata), .mem_done_o(m8_done),
    .ram_addr_o(r8_addr), .ram_we_o(r8_we), .ram_dout_o(r8_dout), .ram_din_i(r8_din)
  );

  // Synchronous RAMs: read data for the sampled address appears in the following cycle
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[9:0]] <= ram_dout;
    ram_din <= ram[ram_addr[9:0]];
    if (r8_we) ram8[r8_addr] <= r8_dout;
    r8_din <= ram8[r8_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // One load/store on the 32-bit (sel=0) or 8-bit (sel=1) instance, request cycle = 0
  task automatic mem_op(input bit sel, input logic we, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string name);
    int n, lat, wes;
    logic [31:0] rd, ea, aa;
    n   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    lat = 0;
    wes = 0;
    rd  = 32'h0;
    @(negedge clk);
    if (sel) begin
      m8_req = 1'b1; m8_we = we; m8_len = len; m8_addr = addr[7:0]; m8_wdata = wdata;
    end else begin
      m_req = 1'b1; m_we = we; m_len = len; m_addr = addr; m_wdata = wdata;
    end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (sel ? r8_we : ram_we) wes++;
      if (c <= n) begin
        ea = addr + 32'(c) - 32'd1;
        if (sel) ea = {24'h0, ea[7:0]};
        aa = sel ? {24'h0, r8_addr} : ram_addr;
        check({name, " addr"}, aa, ea);
        if (we) check({name, " dout"}, {24'h0, sel ? r8_dout : ram_dout},
                      {24'h0, wdata[8*(c-1) +: 8]});
      end
      if (sel ? m8_done : m_done) begin
        lat = c;
        rd  = sel ? m8_rdata : m_rdata;
      end
    end
    m_req  = 1'b0;
    m8_req = 1'b0;
    check({name, " latency"}, 32'(lat), we ? 32'(n + 1) : 32'(n + 2));
    check({name, " rdata"}, rd, exp);
    check({name, " we cycles"}, 32'(wes), we ? 32'(n) : 32'd0);
    @(negedge clk);
    check({name, " done width"}, {31'h0, sel ? m8_done : m_done}, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    int lat, wes;
    logic [31:0] d;
    lat = 0;
    wes = 0;
    d   = 32'h0;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = addr;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (ram_we) wes++;
      if (c <= 4) check({name, " addr"}, ram_addr, addr + 32'(c) - 32'd1);
      if (if_done) begin
        lat = c;
        d   = if_data;
      end
    end
    if_req = 1'b0;
    check({name, " latency"}, 32'(lat), 32'd6);
    check({name, " data"}, d, exp);
    check({name, " we cycles"}, 32'(wes), 32'd0);
    @(negedge clk);
    check({name, " done width"}, {31'h0, if_done}, 32'h0);
  endtask

  initial begin
    int mlat, ilat, ifseen, dn, wes;
    logic [31:0] mrd, ird;

    rst = 1'b1;
    if_req = 1'b0; if_abort = 1'b0; if_addr = 32'h0;
    m_req = 1'b0; m_we = 1'b0; m_len = 2'd0; m_addr = 32'h0; m_wdata = 32'h0;
    m8_req = 1'b0; m8_we = 1'b0; m8_len = 2'd0; m8_addr = 8'h0; m8_wdata = 32'h0;
    i8_req = 1'b0; i8_abort = 1'b0; i8_addr = 8'h0;

    vecs[0] = '{1'b1, 2'd3, 32'h20,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 2'd1, 32'h22,  32'h0,        32'h0000DEAD};
    vecs[2] = '{1'b0, 2'd0, 32'h21,  32'h0,        32'h000000BE};
    vecs[3] = '{1'b0, 2'd3, 32'h20,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 2'd3, 32'h100, 32'h44332211, 32'h0};
    vecs[5] = '{1'b1, 2'd0, 32'h41,  32'h123456A5, 32'h0};
    vecs[6] = '{1'b1, 2'd1, 32'h42,  32'h0000C3B2, 32'h0};
    vecs[7] = '{1'b1, 2'd0, 32'h40,  32'h00000077, 32'h0};
    vecs[8] = '{1'b0, 2'd2, 32'h40,  32'h0,        32'hC3B2A577};
    vecs[9] = '{1'b1, 2'd3, 32'h60,  32'hCAFEF00D, 32'h0};

    repeat (3) @(negedge clk);
    check("rst ram_addr", ram_addr, 32'h0);
    check("rst ram_we", {31'h0, ram_we}, 32'h0);
    check("rst ram_dout", {24'h0, ram_dout}, 32'h0);
    check("rst if_done", {31'h0, if_done}, 32'h0);
    check("rst mem_done", {31'h0, m_done}, 32'h0);
    check("rst if_data", if_data, 32'h0);
    check("rst mem_rdata", m_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      mem_op(1'b0, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
             $sformatf("vec%0d", i));

    fetch(32'h100, 32'h44332211, "fetch");

    // Both requesters together: MEM first, IF only after the dead cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    m_req = 1'b1; m_we = 1'b0; m_len = 2'd0; m_addr = 32'h23;
    mlat = 0; ilat = 0; mrd = 32'h0; ird = 32'h0;
    for (int c = 1; c <= 30 && ilat == 0; c++) begin
      @(negedge clk);
      if (m_done && mlat == 0) begin mlat = c; mrd = m_rdata; m_req = 1'b0; end
      if (if_done) begin ilat = c; ird = if_data; if_req = 1'b0; end
    end
    if_req = 1'b0; m_req = 1'b0;
    check("simul mem latency", 32'(mlat), 32'd3);
    check("simul mem data", mrd, 32'h000000DE);
    check("simul if latency", 32'(ilat), 32'd10);
    check("simul if data", ird, 32'h44332211);
    @(negedge clk);

    // Abort on the 3rd transaction cycle with a load waiting behind the fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mlat = 0; ifseen = 0; mrd = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_done) ifseen++;
      if (m_done && mlat == 0) begin mlat = c; mrd = m_rdata; m_req = 1'b0; end
      if (c == 1) begin m_req = 1'b1; m_we = 1'b0; m_len = 2'd0; m_addr = 32'h23; end
      if (c == 3) begin if_abort = 1'b1; if_req = 1'b0; end
      if (c == 4) begin if_abort = 1'b0; check("abort addr", ram_addr, 32'h0); end
      if (c == 5) check("abort mem grant addr", ram_addr, 32'h23);
    end
    m_req = 1'b0;
    check("abort no if_done", 32'(ifseen), 32'd0);
    check("abort mem latency", 32'(mlat), 32'd7);
    check("abort mem data", mrd, 32'h000000DE);

    // Abort coinciding with the final capture edge
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    ifseen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_done) ifseen++;
      if (c == 5) if_abort = 1'b1;
      if (c == 6) begin
        if_abort = 1'b0; if_req = 1'b0;
        check("late abort addr", ram_addr, 32'h0);
      end
    end
    check("late abort no if_done", 32'(ifseen), 32'd0);

    // Reset while the second byte of a word store is on the RAM port
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b1; m_len = 2'd3; m_addr = 32'h60; m_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst store ram_we", {31'h0, ram_we}, 32'h0);
    check("rst store ram_addr", ram_addr, 32'h0);
    check("rst store ram_dout", {24'h0, ram_dout}, 32'h0);
    check("rst store dones", {30'h0, m_done, if_done}, 32'h0);
    rst = 1'b0; m_req = 1'b0;
    dn = 0; wes = 0;
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      if (m_done || if_done) dn++;
      if (ram_we) wes++;
    end
    check("rst store no done", 32'(dn), 32'd0);
    check("rst store idle we", 32'(wes), 32'd0);
    mem_op(1'b0, 1'b0, 2'd3, 32'h60, 32'h0, 32'hCAFE3344, "post-reset load");

    mem_op(1'b1, 1'b1, 2'd3, 32'hFE, 32'hD4C3B2A1, 32'h0, "wrap store");
    mem_op(1'b1, 1'b0, 2'd3, 32'hFE, 32'h0, 32'hD4C3B2A1, "wrap load");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
